apb_reg_slave: RTL and testbench

APB4 completer that terminates the APB bus driven by the team's APB master and exposes a bank of word-wide read/write registers to the rest of the design. It decodes the address and applies byte strobes on writes. It inserts a fixed, parameterised number of wait states per transfer and flags out-of-range or misaligned accesses with PSLVERR. Register contents are also driven out in parallel for use by downstream logic.

---
 rtl/apb_reg_slave.sv | 132 +++++++++++++
 tb/tb_apb_reg_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB4 completer fronting a bank of word-wide R/W registers.
// A fixed number of wait states is inserted into every transfer. Misaligned or
// out-of-range addresses complete with PSLVERR. All registers are also driven out flat.
`timescale 1ns/1ps
module apb_reg_slave #(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned NumRegs    = 8,
   parameter int unsigned WaitStates = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           psel_i,
   input  logic                           penable_i,
   input  logic                           pwrite_i,
   input  logic [AddrWidth-1:0]           paddr_i,
   input  logic [DataWidth-1:0]           pwdata_i,
   input  logic [DataWidth/8-1:0]         pstrb_i,
   input  logic [2:0]                     pprot_i,
   output logic                           pready_o,
   output logic [DataWidth-1:0]           prdata_o,
   output logic                           pslverr_o,
   output logic [NumRegs*DataWidth-1:0]   regs_out_o
);

   localparam int unsigned CntW = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;
   localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam int unsigned NumBytes = DataWidth / 8;
   localparam logic [AddrWidth-3:0] NumRegsW = (AddrWidth - 2)'(NumRegs);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DataWidth-1:0]  regs_q [NumRegs];
   logic [DataWidth-1:0]  regs_d [NumRegs];

   logic [AddrWidth-3:0]  word_addr;
   logic [IdxW-1:0]       idx;
   logic                  err;
   logic                  wr_commit;

   // pprot is accepted but carries no meaning for this register bank.
   logic unused_pprot;
   assign unused_pprot = ^pprot_i;

   // Address decode: word index plus alignment/range error.
   always_comb begin
      word_addr = paddr_i[AddrWidth-1:2];
      idx       = word_addr[IdxW-1:0];
      err       = (paddr_i[1:0] != 2'b00) || (word_addr >= NumRegsW);
   end

   // FSM next state, wait-state counter and bus response.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Only a genuine setup phase starts a transfer.
            if (psel_i && !penable_i) begin
               state_d = StAccess;
               cnt_d   = CntW'(WaitStates);
            end
         end
         StAccess: begin
            if (!psel_i) begin
               // Master abandoned the transfer: drop it without side effects.
               state_d = StIdle;
            end else if (penable_i) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntW'(1);
               end else begin
                  pready_o = 1'b1;
                  state_d  = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      pslverr_o = pready_o & err;
      wr_commit = pready_o & pwrite_i & ~err;
   end

   // Read data is only presented on a successful read completion.
   always_comb begin
      prdata_o = '0;
      if (pready_o && !pwrite_i && !err) begin
         prdata_o = regs_q[idx];
      end
   end

   // Byte-strobed register update on a committed write.
   always_comb begin
      for (int k = 0; k < NumRegs; k++) begin
         regs_d[k] = regs_q[k];
      end
      if (wr_commit) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (pstrb_i[b]) begin
               regs_d[idx][8*b +: 8] = pwdata_i[8*b +: 8];
            end
         end
      end
   end

   // State, counter and register bank.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         for (int k = 0; k < NumRegs; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int k = 0; k < NumRegs; k++) begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   // Flatten the register bank for downstream logic.
   always_comb begin
      for (int k = 0; k < NumRegs; k++) begin
         regs_out_o[k*DataWidth +: DataWidth] = regs_q[k];
      end
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed APB transfers with a scoreboard queue of expected
// responses, popped by a monitor whenever the DUT signals pready.
`timescale 1ns/1ps
module tb_apb_reg_slave;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned NR = 8;
   localparam int unsigned WS = 1;

   logic              clk;
   logic              rst_n;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [AW-1:0]     paddr;
   logic [DW-1:0]     pwdata;
   logic [DW/8-1:0]   pstrb;
   logic [2:0]        pprot;
   logic              pready;
   logic [DW-1:0]     prdata;
   logic              pslverr;
   logic [NR*DW-1:0]  regs_out;

   apb_reg_slave #(
      .DataWidth (DW),
      .AddrWidth (AW),
      .NumRegs   (NR),
      .WaitStates(WS)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .psel_i    (psel),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .pstrb_i   (pstrb),
      .pprot_i   (pprot),
      .pready_o  (pready),
      .prdata_o  (prdata),
      .pslverr_o (pslverr),
      .regs_out_o(regs_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp  = 0;
   int            n_fail = 0;
   int            xfer_id = 0;
   logic [DW-1:0] model [NR];
   logic [NR*DW-1:0] model_flat;

   task automatic check(input string name, input logic [NR*DW-1:0] act,
                        input logic [NR*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] flat_model();
      logic [NR*DW-1:0] f;
      for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
      return f;
   endfunction

   // Monitor: every pready must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && pready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pready: got pready=1 expected no transfer");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("xfer%0d_prdata", e.id), NR*DW'(prdata), NR*DW'(e.rdata));
            check($sformatf("xfer%0d_pslverr", e.id), NR*DW'(pslverr), NR*DW'(e.err));
         end
      end
   end

   // Full APB transfer; leaves the bus driven so the next one can follow back-to-back.
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW/8-1:0] strb, input logic [DW-1:0] exp_rdata,
                       input logic exp_err);
      exp_t e;
      int   cycles;
      @(posedge clk); #1;
      xfer_id++;
      e.id = xfer_id; e.rdata = exp_rdata; e.err = exp_err;
      sb.push_back(e);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge clk); #1;
      penable = 1'b1;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!pready && cycles < 20);
      check($sformatf("xfer%0d_access_cycles", xfer_id), NR*DW'(cycles), NR*DW'(WS + 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         psel = 1'b0; penable = 1'b0;
      end
   endtask

   initial begin
      psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b010;
      for (int k = 0; k < NR; k++) model[k] = '0;

      // Reset held with a toggling bus.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         psel = ~psel; penable = i[0]; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hFFFF_FFFF;
         pstrb = 4'hF;
         @(negedge clk);
         check("rst_pready", NR*DW'(pready), '0);
         check("rst_pslverr", NR*DW'(pslverr), '0);
         check("rst_prdata", NR*DW'(prdata), '0);
         check("rst_regs_out", regs_out, '0);
      end
      @(posedge clk); #1;
      psel = 0; penable = 0; pwrite = 0;
      @(negedge clk); rst_n = 1'b1;

      xfer(1'b0, 32'h4, '0, 4'h0, 32'h0, 1'b0);

      // Full-word write and readback.
      xfer(1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      model[3] = 32'hDEAD_BEEF;
      xfer(1'b0, 32'hC, '0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      idle(1);
      check("reg3_regs_out", regs_out, flat_model());

      // Byte strobes.
      xfer(1'b1, 32'h8, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
      xfer(1'b1, 32'h8, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
      model[2] = 32'h11BB_33DD;
      xfer(1'b0, 32'h8, '0, 4'hF, 32'h11BB_33DD, 1'b0);

      // Zero strobe write leaves reg3 alone.
      xfer(1'b1, 32'hC, 32'h0, 4'h0, 32'h0, 1'b0);
      xfer(1'b0, 32'hC, '0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // Error responses.
      xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      xfer(1'b0, 32'h6, '0, 4'h0, 32'h0, 1'b1);
      xfer(1'b1, 32'hE, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      idle(1);
      check("err_no_change", regs_out, flat_model());

      // Back-to-back write then read of reg1.
      xfer(1'b1, 32'h4, 32'h1, 4'hF, 32'h0, 1'b0);
      model[1] = 32'h1;
      xfer(1'b0, 32'h4, '0, 4'h0, 32'h1, 1'b0);
      idle(1);
      check("b2b_regs_out", regs_out, flat_model());

      // psel+penable without setup is ignored.
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h5A5A_5A5A;
      pstrb = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_setup_pready", NR*DW'(pready), '0);
      end
      idle(1);
      check("no_setup_regs", regs_out, flat_model());

      // Abort: drop psel during the wait cycle of a write to reg0.
      xfer(1'b1, 32'h0, 32'h0000_00AA, 4'hF, 32'h0, 1'b0);
      model[0] = 32'h0000_00AA;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1234_5678;
      pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("abort_wait_pready", NR*DW'(pready), '0);
      idle(2);
      check("abort_regs", regs_out, flat_model());
      xfer(1'b0, 32'h0, '0, 4'h0, 32'h0000_00AA, 1'b0);

      // Reset asserted during an access.
      xfer(1'b1, 32'h14, 32'h5555_5555, 4'hF, 32'h0, 1'b0);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h7777_7777;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NR; k++) model[k] = '0;
      check("midrst_pready", NR*DW'(pready), '0);
      check("midrst_regs", regs_out, '0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      xfer(1'b0, 32'h14, '0, 4'h0, 32'h0, 1'b0);
      idle(2);

      check("sb_drained", NR*DW'(sb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
